// File: rtl/usb_pkg.sv
// usb_pkg: shared widths and FSM state encodings for the FT245 transmit path
package usb_pkg;
  localparam int USB_BYTE_W  = 8;
  localparam int BYTECOUNT_W = 16;
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SETUP  = 4'd1,
    STROBE = 4'd2,
    HOLD   = 4'd3
  } usb_state_e;
endpackage

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: power-of-2 circular byte buffer with occupancy count and show-ahead head
module usb_tx_fifo
  import usb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = USB_BYTE_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  // storage needs no reset; only entries below the write pointer are ever read
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  // pointers wrap naturally at DEPTH because DEPTH is a power of 2
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
endmodule

// File: rtl/usb_output.sv
// usb_output: FT245 transmit side, buffers producer bytes and strobes them out gated by TXE#; USB_TX_BYTECOUNT_EN enables the bytes_sent counter
module usb_output
  import usb_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int SETUP_CYCLES   = 1,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int WR_LOW_CYCLES  = 3
) (
  input  logic                    clock,
  input  logic                    reset_b,
  input  logic [USB_BYTE_W-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [USB_BYTE_W-1:0]   usb_data,
  output logic                    usb_oe,
  output logic                    wr,
  input  logic                    txe,
  output logic [$clog2(DEPTH):0]  count,
  output logic [BYTECOUNT_W-1:0]  bytes_sent,
  output logic [3:0]              state
);
  localparam int CW = 8;
  usb_state_e            state_q;
  logic [CW-1:0]         cyc_q;
  logic                  txe_meta_q, txe_s_q, wr_q, oe_q;
  logic [USB_BYTE_W-1:0] data_q, head;
  logic                  full, empty, push, pop, strobe_done;
  assign in_ready    = reset_b & ~full;
  assign push        = in_valid & in_ready;
  assign pop         = (state_q == IDLE) & ~empty & ~txe_s_q;
  assign strobe_done = (state_q == STROBE) && (cyc_q == CW'(WR_HIGH_CYCLES - 1));
  assign usb_data    = data_q;
  assign usb_oe      = oe_q;
  assign wr          = wr_q;
  assign state       = state_q;
  usb_tx_fifo #(.DEPTH(DEPTH), .W(USB_BYTE_W)) u_fifo (
    .clk    (clock),
    .rst_n  (reset_b),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(in_data),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  // two-flop TXE# synchronizer; resets to "FTDI full" so nothing is sent until it settles
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) begin
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      txe_meta_q <= txe;
      txe_s_q    <= txe_meta_q;
    end
  // strobe sequencer: TXE# is only looked at in IDLE, so a started strobe always completes
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (pop) begin
            data_q  <= head;
            oe_q    <= 1'b1;
            state_q <= SETUP;
          end
        SETUP:
          if (cyc_q == CW'(SETUP_CYCLES - 1)) begin
            cyc_q   <= '0;
            wr_q    <= 1'b1;
            state_q <= STROBE;
          end else cyc_q <= cyc_q + CW'(1);
        STROBE:
          if (strobe_done) begin
            cyc_q   <= '0;
            wr_q    <= 1'b0;
            state_q <= HOLD;
          end else cyc_q <= cyc_q + CW'(1);
        HOLD:
          if (cyc_q == CW'(WR_LOW_CYCLES - 1)) begin
            cyc_q   <= '0;
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end else cyc_q <= cyc_q + CW'(1);
        default: state_q <= IDLE;
      endcase
    end
`ifdef USB_TX_BYTECOUNT_EN
  logic [BYTECOUNT_W-1:0] bytes_q;
  // counts completed strobes (wr falling edges), wrapping at the counter width
  always_ff @(posedge clock or negedge reset_b)
    if (!reset_b) bytes_q <= '0;
    else if (strobe_done) bytes_q <= bytes_q + BYTECOUNT_W'(1);
  assign bytes_sent = bytes_q;
`else
  assign bytes_sent = '0;
`endif
endmodule

// File: tb/tb_usb_output.sv
// tb_usb_output: directed stimulus against a timeline model of the FT245 transmit path
module tb_usb_output;
  localparam int D = 16, S = 1, H = 2, L = 3;
  logic        clock = 1'b0, reset_b = 1'b0, in_valid = 1'b0, txe = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, usb_oe, wr;
  logic [7:0]  usb_data;
  logic [4:0]  count;
  logic [15:0] bytes_sent;
  logic [3:0]  state;
  int n_chk = 0, n_fail = 0;

  usb_output #(.DEPTH(D), .SETUP_CYCLES(S), .WR_HIGH_CYCLES(H), .WR_LOW_CYCLES(L)) dut (
    .clock(clock), .reset_b(reset_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .usb_data(usb_data), .usb_oe(usb_oe), .wr(wr), .txe(txe),
    .count(count), .bytes_sent(bytes_sent), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of buffered bytes, the TXE# sample pipeline, and the offset of the
  // current transfer since the IDLE cycle that popped it (1..S+H+L while busy).
  logic [7:0] mq[$];
  logic       m_s1 = 1'b1, m_s2 = 1'b1, m_busy = 1'b0, m_acc;
  int         m_t = 0;
  logic [7:0] m_byte = '0;
  logic [15:0] m_sent = '0;

  always @(posedge clock or negedge reset_b)
    if (!reset_b) begin
      mq.delete();
      m_s1 = 1'b1; m_s2 = 1'b1; m_busy = 1'b0; m_t = 0; m_byte = '0; m_sent = '0;
    end else begin
      m_acc = in_valid && mq.size() < D;
      if (m_busy) begin
        if (m_t == S + H) m_sent = m_sent + 16'd1;
        if (m_t == S + H + L) m_busy = 1'b0;
        else m_t = m_t + 1;
      end else if (mq.size() > 0 && !m_s2) begin
        m_byte = mq.pop_front();
        m_busy = 1'b1;
        m_t = 1;
      end
      if (m_acc) mq.push_back(in_data);
      m_s2 = m_s1;
      m_s1 = txe;
    end

  always @(negedge clock) begin
    logic [3:0] e_state;
    e_state = !m_busy ? 4'd0 : m_t <= S ? 4'd1 : m_t <= S + H ? 4'd2 : 4'd3;
    chk("m_usb_oe", usb_oe, m_busy);
    chk("m_wr", wr, m_busy && m_t > S && m_t <= S + H);
    chk("m_usb_data", usb_data, m_byte);
    chk("m_in_ready", in_ready, reset_b && mq.size() < D);
    chk("m_count", count, mq.size());
    chk("m_state", state, e_state);
`ifdef USB_TX_BYTECOUNT_EN
    chk("m_bytes_sent", bytes_sent, m_sent);
`else
    chk("m_bytes_sent", bytes_sent, 0);
`endif
  end

  task automatic push(input logic [7:0] d);
    int k = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clock);
    while (!in_ready && k < 300) begin
      @(negedge clock);
      k++;
    end
    if (!in_ready) chk("push_timeout", in_ready, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_wr();
    int k = 0;
    while (!wr && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("wr_rise_timeout", wr, 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_oe", usb_oe, 0);
    @(posedge clock);
    #1 reset_b = 1'b1;
    settle(3);
    chk("ready_after_reset", in_ready, 1);
    // single byte: usb_oe at N+2, wr high N+3..N+4
    push(8'hA5);
    @(negedge clock); chk("single_n1_oe", usb_oe, 0); chk("single_n1_count", count, 1);
    @(negedge clock); chk("single_n2_oe", usb_oe, 1); chk("single_n2_wr", wr, 0); chk("single_n2_data", usb_data, 8'hA5);
    @(negedge clock); chk("single_n3_wr", wr, 1);
    @(negedge clock); chk("single_n4_wr", wr, 1); chk("single_n4_data", usb_data, 8'hA5);
    @(negedge clock); chk("single_n5_wr", wr, 0); chk("single_n5_oe", usb_oe, 1);
    settle(10);
    // back-to-back 0x00..0x0F
    for (int i = 0; i < 16; i++) push(8'(i));
    settle(16 * 7 + 10);
    chk("b2b_drained", count, 0);
    // flow control
    txe = 1'b1;
    settle(4);
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
    settle(5);
    chk("flow_count", count, 3);
    chk("flow_no_wr", wr, 0);
    txe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); chk("flow_oe_wait", usb_oe, 0);
    end
    @(negedge clock); chk("flow_oe_start", usb_oe, 1);
    settle(30);
    // TXE# rises mid-strobe
    push(8'h5A);
    push(8'h5B);
    wait_wr();
    txe = 1'b1;
    @(negedge clock); chk("mid_wr_held", wr, 1);
    repeat (12) @(negedge clock);
    chk("mid_next_oe", usb_oe, 0);
    chk("mid_next_wr", wr, 0);
    chk("mid_count", count, 1);
    txe = 1'b0;
    settle(20);
    // full buffer, 17th byte held until first pop
    txe = 1'b1;
    settle(4);
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    @(negedge clock); chk("full_count", count, 16); chk("full_ready", in_ready, 0);
    txe = 1'b0;
    push(8'h90);
    settle(17 * 7 + 10);
    chk("full_drained", count, 0);
    // reset during STROBE
    push(8'h3C);
    wait_wr();
    #2 reset_b = 1'b0;
    #1;
    chk("arst_wr", wr, 0);
    chk("arst_oe", usb_oe, 0);
    chk("arst_count", count, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset_b = 1'b1;
    settle(20);
    chk("post_rst_wr", wr, 0);
    chk("post_rst_oe", usb_oe, 0);
    chk("post_rst_state", state, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_output.md
Name: usb_output

Overview:
- Transmit side of the FTDI FT245 parallel FIFO link; counterpart of usb_input. It sends bytes from the FPGA to the host PC, for example for flash readback dumps and debug telemetry.
- An internal producer (audio/flash manager) pushes bytes through a valid/ready handshake into a small buffer.
- An FSM drains the buffer onto the shared FTDI data bus with correctly timed WR strobes, gated by TXE#.

Parameters:
- DEPTH, 16: buffer entries; must be a power of 2, at least 2.
- SETUP_CYCLES, 1: cycles data is driven before WR rises; at least 1.
- WR_HIGH_CYCLES, 2: WR high width; 2 cycles = 74 ns at 27 MHz, against the ≥50 ns minimum.
- WR_LOW_CYCLES, 3: post-strobe hold/recovery; at least 3 to cover the 2-flop TXE# synchronizer.

Ports:
- clock  in  1  27 MHz system clock.
- reset_b  in  1  asynchronous, active-low reset.
- in_data  in  8  byte from producer.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  buffer can accept; equals ~full.
- usb_data  out  8  byte driven toward FTDI D[7:0]; top level tristates it with usb_oe.
- usb_oe  out  1  1 = FPGA drives the FTDI data bus.
- wr  out  1  FTDI WR strobe, active high; byte latched on its falling edge.
- txe  in  1  FTDI TXE#, active low; 0 = FTDI has room.
- count  out  $clog2(DEPTH)+1  current buffer occupancy.
- bytes_sent  out  16  bytes strobed out (see Optional Feature).
- state  out  4  FSM state, for debug.

Behaviour:
- Reset (async assert, sync deassert inside the block): wr=0, usb_oe=0, usb_data=0, count=0, in_ready=0 while reset_b=0 and 1 afterwards, state=IDLE, bytes_sent=0, synchronizer flops=1 (meaning "FTDI full").
- txe passes through a 2-flop synchronizer; txe_s is its output.
- Push: in_valid & in_ready writes in_data at the write pointer; count+1 next cycle. in_valid while full is ignored; the producer must hold the byte.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance.

FSM:
- IDLE: usb_oe=0, wr=0.
  - If count≠0 and txe_s=0: pop head into the data register, usb_oe=1, go SETUP.
- SETUP: hold for SETUP_CYCLES, wr=0; then go STROBE.
- STROBE: wr=1 for WR_HIGH_CYCLES; then wr=0, bytes_sent+1, go HOLD.
- HOLD: usb_oe=1 and data held for WR_LOW_CYCLES; then usb_oe=0, go IDLE.
- A TXE# change after a strobe starts never aborts it; TXE# is sampled only in IDLE.
- Latency: byte pushed at cycle N, buffer previously empty, txe_s=0 → IDLE sees count≠0 at N+1, usb_oe=1 at N+2, wr rises at N+2+SETUP_CYCLES.
- Throughput: one byte per 1+SETUP_CYCLES+WR_HIGH_CYCLES+WR_LOW_CYCLES cycles = 7 at defaults.
- Reset mid-strobe: wr and usb_oe drop immediately (async); the buffered bytes are lost. This is accepted.
- usb_data is stable from SETUP entry through the end of HOLD.

Optional Feature:
- USB_TX_BYTECOUNT_EN defined: bytes_sent is a 16-bit counter, incremented on each wr falling edge, wrapping 0xFFFF→0x0000. Used to confirm the number of bytes delivered on a flash dump.
- Undefined: bytes_sent tied to 16'h0 and no counter logic inferred.

Decomposition:
- Package usb_pkg:
  - state encodings IDLE=0, SETUP=1, STROBE=2, HOLD=3;
  - USB_BYTE_W=8;
  - BYTECOUNT_W=16.
- The 2-flop synchronizer is inline.
- One sub-module: usb_tx_fifo (DEPTH, width 8, push/pop/full/empty/count), reusable later for a receive-side buffer.

Test Plan:
- Single byte: txe=0, push 8'hA5 → usb_oe rises at N+2; wr high 2 cycles at N+3..N+4; usb_data=A5 throughout; bytes_sent=1.
- Back-to-back: push 16'h00..0F with txe=0 → 16 strobes, in order, 7 cycles apart. in_ready drops after the 16th push if the first byte is not yet popped.
- Flow control: txe=1, push 3 bytes → no wr, count=3. Release txe=0 → 3 strobes begin 3 cycles after the release.
- TXE# rises mid-STROBE → strobe completes with the full WR width. The next byte waits until txe_s=0.
- Full buffer: push 17 bytes with txe=1 → count=16, in_ready=0; the 17th is held by the producer and accepted after the first pop.
- Reset: assert reset_b=0 during STROBE → wr=0 and usb_oe=0 asynchronously, count=0. After release the block is idle with no strobe.
